// File: rtl/ray_dispatcher_pkg.sv
// ray_dispatcher_pkg: control state encoding for the frame dispatcher.
package ray_dispatcher_pkg;
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DRAIN} state_e;
endpackage

// File: rtl/vector_arith.sv
// vector_arith: shared fixed-point vector types for the ray pipeline.
package vector_arith;
    typedef logic signed [15:0] fp;
    typedef struct packed {
        fp x;
        fp y;
        fp z;
    } vec3;
endpackage

// File: rtl/ray_dispatcher_raster_counter.sv
// raster_counter: raster-order pixel counter with clear, advance and last-pixel flag.
module raster_counter #(
    parameter int W  = 4,
    parameter int H  = 2,
    parameter int HB = 3,
    parameter int VB = 2
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          clear_i,
    input  logic          advance_i,
    output logic [HB-1:0] h_o,
    output logic [VB-1:0] v_o,
    output logic          last_o
);
    logic [HB-1:0] h_q, h_d;
    logic [VB-1:0] v_q, v_d;
    logic          h_end, v_end;

    always_comb begin
        h_end  = h_q == HB'(W - 1);
        v_end  = v_q == VB'(H - 1);
        h_d    = clear_i ? '0 : advance_i ? (h_end ? '0 : h_q + HB'(1)) : h_q;
        v_d    = clear_i ? '0 : (advance_i && h_end) ? (v_end ? '0 : v_q + VB'(1)) : v_q;
        last_o = h_end && v_end;
        h_o    = h_q;
        v_o    = v_q;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            h_q <= '0;
            v_q <= '0;
        end else begin
            h_q <= h_d;
            v_q <= v_d;
        end
    end
endmodule

// File: rtl/ray_dispatcher.sv
// ray_dispatcher: walks a frame in raster order, issues pixels to the ray generator
// and forwards tagged ray directions through a one-entry output register.
`ifndef DISPLAY_WIDTH
`define DISPLAY_WIDTH 320
`endif
`ifndef DISPLAY_HEIGHT
`define DISPLAY_HEIGHT 180
`endif
`ifndef H_BITS
`define H_BITS 9
`endif
`ifndef V_BITS
`define V_BITS 8
`endif

module ray_dispatcher
    import vector_arith::*;
    import ray_dispatcher_pkg::*;
#(
    parameter int DISPLAY_WIDTH  = `DISPLAY_WIDTH,
    parameter int DISPLAY_HEIGHT = `DISPLAY_HEIGHT,
    parameter int H_BITS         = `H_BITS,
    parameter int V_BITS         = `V_BITS
) (
    input  logic              clk_in,
    input  logic              rst_in_n,
    input  logic              start_in,
    input  vec3               cam_forward_in,
    output logic              gen_valid_out,
    output logic [H_BITS-1:0] gen_hcount_out,
    output logic [V_BITS-1:0] gen_vcount_out,
    output vec3               gen_cam_forward_out,
    input  logic              gen_ready_in,
    input  logic              gen_valid_in,
    input  vec3               gen_ray_direction_in,
    output logic              ray_valid_out,
    input  logic              ray_ready_in,
    output vec3               ray_direction_out,
    output logic [H_BITS-1:0] ray_hcount_out,
    output logic [V_BITS-1:0] ray_vcount_out,
    output logic              busy_out,
    output logic              frame_done_out
);
    state_e            state_q, state_d;
    vec3               cam_q, cam_d, rdir_q, rdir_d;
    logic [H_BITS-1:0] ih, tag_h_q, tag_h_d, rh_q, rh_d;
    logic [V_BITS-1:0] iv, tag_v_q, tag_v_d, rv_q, rv_d;
    logic              last_q, last_d, rval_q, rval_d, done_q, done_d;
    logic              cnt_last, start, xfer, cap, fin;

    raster_counter #(
        .W (DISPLAY_WIDTH),
        .H (DISPLAY_HEIGHT),
        .HB(H_BITS),
        .VB(V_BITS)
    ) u_raster (
        .clk_i    (clk_in),
        .rst_ni   (rst_in_n),
        .clear_i  (start),
        .advance_i(xfer),
        .h_o      (ih),
        .v_o      (iv),
        .last_o   (cnt_last)
    );

    always_ff @(posedge clk_in or negedge rst_in_n) begin
        if (!rst_in_n) begin
            state_q <= IDLE;
            cam_q   <= '0;
            tag_h_q <= '0;
            tag_v_q <= '0;
            last_q  <= 1'b0;
            rval_q  <= 1'b0;
            rdir_q  <= '0;
            rh_q    <= '0;
            rv_q    <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cam_q   <= cam_d;
            tag_h_q <= tag_h_d;
            tag_v_q <= tag_v_d;
            last_q  <= last_d;
            rval_q  <= rval_d;
            rdir_q  <= rdir_d;
            rh_q    <= rh_d;
            rv_q    <= rv_d;
            done_q  <= done_d;
        end
    end

    // A capture may coincide with a downstream handshake; the new entry then replaces the old one.
    always_comb begin
        start   = state_q == IDLE && start_in;
        xfer    = state_q == ISSUE && gen_ready_in;
        cap     = state_q == WAIT && gen_valid_in && (!rval_q || ray_ready_in);
        fin     = state_q == DRAIN && rval_q && ray_ready_in;
        state_d = start ? ISSUE : xfer ? WAIT : cap ? (last_q ? DRAIN : ISSUE) : fin ? IDLE : state_q;
        cam_d   = start ? cam_forward_in : cam_q;
        tag_h_d = xfer ? ih : tag_h_q;
        tag_v_d = xfer ? iv : tag_v_q;
        last_d  = xfer ? cnt_last : last_q;
        rval_d  = cap || (rval_q && !ray_ready_in);
        rdir_d  = cap ? gen_ray_direction_in : rdir_q;
        rh_d    = cap ? tag_h_q : rh_q;
        rv_d    = cap ? tag_v_q : rv_q;
        done_d  = fin;
    end

    always_comb begin
        gen_valid_out       = state_q == ISSUE;
        busy_out            = state_q != IDLE;
        gen_hcount_out      = ih;
        gen_vcount_out      = iv;
        gen_cam_forward_out = cam_q;
        ray_valid_out       = rval_q;
        ray_direction_out   = rdir_q;
        ray_hcount_out      = rh_q;
        ray_vcount_out      = rv_q;
        frame_done_out      = done_q;
    end
endmodule

// File: tb/tb_ray_dispatcher.sv
// tb_ray_dispatcher: scoreboard bench for ray_dispatcher with a latency-3 generator model.
module tb_ray_dispatcher;
    import vector_arith::*;

    localparam int W = 4, H = 2, HB = 3, VB = 2, L = 3, N = W * H;

    logic clk = 1'b0, rst_n = 1'b0, start = 1'b0, gen_ready = 1'b1, ray_ready = 1'b1;
    vec3 cam = '0;
    logic gen_valid_out, ray_valid_out, busy_out, frame_done_out;
    logic [HB-1:0] gen_h, ray_h;
    logic [VB-1:0] gen_v, ray_v;
    vec3 gen_cam, ray_dir;
    logic g_valid, g_pend;
    int g_cnt;
    vec3 g_dir;

    int n_tests = 0, n_fail = 0;
    int req_idx = 0, ray_idx = 0, rays_total = 0, done_cnt = 0, cyc = 0, last_xfer = -1, gap = 0;
    logic pend_done = 0, prev_gv_stall = 0, prev_rv_stall = 0;
    logic [52:0] prev_ray = '0;
    logic [47:0] last_dir = '0;
    vec3 frame_cam = '0;

    localparam logic [47:0] CAM_A = 48'h0000_0000_0100, CAM_B = 48'h0100_ff00_0080;

    always #5 clk = ~clk;

    ray_dispatcher #(
        .DISPLAY_WIDTH(W), .DISPLAY_HEIGHT(H), .H_BITS(HB), .V_BITS(VB)
    ) dut (
        .clk_in(clk), .rst_in_n(rst_n), .start_in(start), .cam_forward_in(cam),
        .gen_valid_out(gen_valid_out), .gen_hcount_out(gen_h), .gen_vcount_out(gen_v),
        .gen_cam_forward_out(gen_cam), .gen_ready_in(gen_ready), .gen_valid_in(g_valid),
        .gen_ray_direction_in(g_dir), .ray_valid_out(ray_valid_out), .ray_ready_in(ray_ready),
        .ray_direction_out(ray_dir), .ray_hcount_out(ray_h), .ray_vcount_out(ray_v),
        .busy_out(busy_out), .frame_done_out(frame_done_out)
    );

    function automatic logic [47:0] mkdir(int h, int v);
        return {16'(h * 256), 16'(v * 256), 16'd256};
    endfunction

    task automatic check(string name, logic [63:0] act, logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Generator: result valid L edges after accept, held until the next accept.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            g_valid <= 1'b0; g_pend <= 1'b0; g_cnt <= 0; g_dir <= '0;
        end else if (gen_valid_out && gen_ready) begin
            g_valid <= 1'b0; g_pend <= 1'b1; g_cnt <= 1; g_dir <= mkdir(int'(gen_h), int'(gen_v));
        end else if (g_pend) begin
            g_cnt <= g_cnt + 1;
            if (g_cnt == L) begin g_valid <= 1'b1; g_pend <= 1'b0; end
        end
    end

    always @(negedge clk) begin
        cyc++;
        if (!rst_n) begin
            check("rst_ctrl", {gen_valid_out, ray_valid_out, busy_out, frame_done_out}, 0);
            check("rst_data", {gen_h, gen_v, gen_cam, ray_h, ray_v, ray_dir}, 0);
            req_idx = 0; ray_idx = 0; pend_done = 0; prev_gv_stall = 0; prev_rv_stall = 0;
        end else begin
            if (pend_done) check("done_pulse", {frame_done_out, busy_out}, 2'b10);
            else check("done_quiet", frame_done_out, 0);
            if (frame_done_out) done_cnt++;
            pend_done = 0;
            if (prev_gv_stall) check("gv_hold", gen_valid_out, 1);
            if (prev_rv_stall) check("ray_hold", {ray_valid_out, ray_h, ray_v, ray_dir}, {1'b1, prev_ray});
            if (busy_out) check("cam_hold", gen_cam, frame_cam);
            if (!busy_out && start) begin
                req_idx = 0; ray_idx = 0; frame_cam = cam;
            end
            if (gen_valid_out && gen_ready) begin
                check("req_count", req_idx < N, 1);
                check("req_xy", {gen_h, gen_v}, {HB'(req_idx % W), VB'(req_idx / W)});
                req_idx++;
                if (last_xfer >= 0) gap = cyc - last_xfer;
                last_xfer = cyc;
            end
            if (ray_valid_out && ray_ready) begin
                check("ray_count", ray_idx < N, 1);
                check("ray_xy", {ray_h, ray_v}, {HB'(ray_idx % W), VB'(ray_idx / W)});
                check("ray_dir", ray_dir, mkdir(ray_idx % W, ray_idx / W));
                ray_idx++; rays_total++; last_dir = ray_dir;
                if (ray_idx == N) pend_done = 1;
            end
            prev_gv_stall = gen_valid_out && !gen_ready;
            prev_rv_stall = ray_valid_out && !ray_ready;
            prev_ray = {ray_h, ray_v, ray_dir};
        end
    end

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic pulse_start(logic [47:0] c);
        tick(); start = 1'b1; cam = c;
        tick(); start = 1'b0;
    endtask

    task automatic wait_done(int max);
        int k = 0;
        while (!frame_done_out && k < max) begin tick(); k++; end
        check("done_timeout", k < max, 1);
    endtask

    initial begin
        int k;
        repeat (3) tick();
        rst_n = 1'b1;
        tick();
        check("idle_busy", busy_out, 0);

        // Free-running frame with an ignored mid-frame start.
        pulse_start(CAM_A);
        check("start_lat", gen_valid_out, 1);
        repeat (10) tick();
        pulse_start(CAM_B);
        cam = CAM_A;
        wait_done(200);
        tick();
        check("frame_rays", rays_total, 8);
        check("done_once", done_cnt, 1);
        check("last_dir", last_dir, 48'h0300_0100_0100);
        check("pixel_period", gap, L + 2);
        check("cam_kept", gen_cam, CAM_A);

        // Downstream stall: second result held, then same-edge handshake and capture.
        ray_ready = 1'b0;
        pulse_start(CAM_B);
        k = 0;
        while (!ray_valid_out && k < 50) begin tick(); k++; end
        check("first_ray_timeout", k < 50, 1);
        repeat (20) tick();
        check("stall_xy", {ray_valid_out, ray_h, ray_v}, {1'b1, 3'd0, 2'd0});
        check("stall_reqs", req_idx, 2);
        check("stall_gv", {gen_valid_out, g_valid}, 2'b01);
        ray_ready = 1'b1;
        tick();
        check("swap_valid", ray_valid_out, 1);
        check("swap_xy", {ray_h, ray_v}, {3'd1, 2'd0});
        check("swap_dir", ray_dir, 48'h0100_0000_0100);
        wait_done(200);
        tick();
        check("stall_rays", rays_total, 16);

        // Random backpressure on both sides.
        pulse_start(CAM_A);
        k = 0;
        while (!frame_done_out && k < 800) begin
            gen_ready = 1'($urandom_range(0, 1));
            ray_ready = 1'($urandom_range(0, 1));
            tick(); k++;
        end
        check("rand_timeout", k < 800, 1);
        gen_ready = 1'b1; ray_ready = 1'b1;
        tick();
        check("rand_rays", rays_total, 24);

        // Asynchronous reset mid-frame, then a clean frame.
        pulse_start(CAM_B);
        k = 0;
        while (!(gen_valid_out && gen_h == 3'd2) && k < 100) begin tick(); k++; end
        check("px2_timeout", k < 100, 1);
        #2 rst_n = 1'b0;
        #1;
        check("arst_ctrl", {gen_valid_out, ray_valid_out, busy_out, frame_done_out}, 0);
        check("arst_data", {gen_h, gen_v, gen_cam, ray_h, ray_v, ray_dir}, 0);
        repeat (2) tick();
        rst_n = 1'b1;
        tick();
        pulse_start(CAM_A);
        check("restart_xy", {gen_valid_out, gen_h, gen_v}, {1'b1, 3'd0, 2'd0});
        wait_done(200);
        tick();
        check("done_total", done_cnt, 4);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
